spatz_vrf_responder: RTL and testbench



---
 rtl/spatz_vrf_responder_pkg.sv | 14 +
 rtl/spatz_vrf_rr_arb.sv | 48 ++++
 rtl/spatz_vrf_responder.sv | 142 ++++++++++++++
 tb/tb_spatz_vrf_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spatz_vrf_responder_pkg.sv
// Default geometry and shared word types of the Spatz vector register file.
// The responder parameters derive their defaults from these values.
package spatz_vrf_responder_pkg;

    localparam int NrVRFBanks        = 4;
    localparam int NrVRFReadPorts    = 3;
    localparam int NrVRFWordsPerBank = 32;
    localparam int VRFDataWidth      = 128;

    typedef logic [$clog2(NrVRFBanks*NrVRFWordsPerBank)-1:0] vreg_addr_t;
    typedef logic [VRFDataWidth-1:0]                         vreg_data_t;
    typedef logic [VRFDataWidth/8-1:0]                       vreg_be_t;

endpackage

// File: rtl/spatz_vrf_rr_arb.sv
// Round-robin arbiter over NrPorts requesters; pointer moves past the winner only on a grant.
// Latency: combinational grant, pointer update at the next clock edge.
// Backpressure: en_i=0 suppresses every grant; requesters keep requesting and the pointer holds.
module spatz_vrf_rr_arb #(
    parameter int NrPorts = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NrPorts-1:0] req_i,
    input  logic               en_i,
    output logic [NrPorts-1:0] gnt_o
);
    localparam int PtrW = (NrPorts > 1) ? $clog2(NrPorts) : 1;

    logic [PtrW-1:0] ptr_q, ptr_d, win;
    logic            found;

    function automatic logic [PtrW-1:0] rr_idx(input logic [PtrW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NrPorts) s = s - NrPorts;
        return PtrW'(s);
    endfunction

    always_comb begin
        gnt_o = '0;
        win   = ptr_q;
        found = 1'b0;
        for (int i = 0; i < NrPorts; i++) begin
            if (!found && en_i && req_i[rr_idx(ptr_q, i)]) begin
                found = 1'b1;
                win   = rr_idx(ptr_q, i);
            end
        end
        if (found) gnt_o[win] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) ptr_d = (win == PtrW'(NrPorts - 1)) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

endmodule

// File: rtl/spatz_vrf_responder.sv
// VRF responder: banked byte-writable storage, per-bank RR read arbitration, held per-port read responses.
// Latency: read data/rvalid_o one cycle after grant; writes acknowledged (wvalid_o) in the cycle we_i is high.
// Backpressure: a write blocks its bank, losing/blocked reads wait on re_i; SPATZ_VRF_BYPASS_EN forwards write data to a matching read.
module spatz_vrf_responder
    import spatz_vrf_responder_pkg::*;
#(
    parameter int NrReadPorts    = NrVRFReadPorts,
    parameter int NrBanks        = NrVRFBanks,
    parameter int NrWordsPerBank = NrVRFWordsPerBank,
    parameter int DataWidth      = VRFDataWidth,
    parameter int AddrWidth      = $clog2(NrBanks * NrWordsPerBank)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NrReadPorts*AddrWidth-1:0] raddr_i,
    input  logic [NrReadPorts-1:0]           re_i,
    output logic [NrReadPorts*DataWidth-1:0] rdata_o,
    output logic [NrReadPorts-1:0]           rvalid_o,
    input  logic [AddrWidth-1:0]             waddr_i,
    input  logic [DataWidth-1:0]             wdata_i,
    input  logic                             we_i,
    input  logic [DataWidth/8-1:0]           wbe_i,
    output logic                             wvalid_o
);
    localparam int BankW   = $clog2(NrBanks);
    localparam int RowW    = AddrWidth - BankW;
    localparam int NrBytes = DataWidth / 8;

    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [DataWidth-1:0] data_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
        data_t data;
    } resp_t;

    function automatic data_t be_merge(input data_t old_d, input data_t new_d,
                                       input logic [NrBytes-1:0] be);
        data_t res;
        res = old_d;
        for (int b = 0; b < NrBytes; b++) begin
            if (be[b]) res[b*8 +: 8] = new_d[b*8 +: 8];
        end
        return res;
    endfunction

    data_t            mem_q [NrBanks][NrWordsPerBank];
    logic [BankW-1:0] wbank;
    logic [RowW-1:0]  wrow;

    addr_t            raddr   [NrReadPorts];
    logic [BankW-1:0] rbank   [NrReadPorts];
    logic [RowW-1:0]  rrow    [NrReadPorts];
    data_t            row_dat [NrReadPorts];
    resp_t            resp_q  [NrReadPorts];
    resp_t            resp_d  [NrReadPorts];

    logic [NrReadPorts-1:0] pend, fwd, port_gnt;
    logic [NrReadPorts-1:0] bank_req [NrBanks];
    logic [NrReadPorts-1:0] bank_gnt [NrBanks];
    logic [NrBanks-1:0]     bank_free;

    assign wbank    = waddr_i[BankW-1:0];
    assign wrow     = waddr_i[AddrWidth-1:BankW];
    assign wvalid_o = 1'b1;

    // Storage is intentionally not reset; the write always owns its bank for the cycle.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[wbank][wrow] <= be_merge(mem_q[wbank][wrow], wdata_i, wbe_i);
    end

    for (genvar p = 0; p < NrReadPorts; p++) begin : g_port
        assign raddr[p]   = raddr_i[p*AddrWidth +: AddrWidth];
        assign rbank[p]   = raddr[p][BankW-1:0];
        assign rrow[p]    = raddr[p][AddrWidth-1:BankW];
        assign row_dat[p] = mem_q[rbank[p]][rrow[p]];

        // A response only counts while the VFU still asks for the very word it holds.
        assign rvalid_o[p] = resp_q[p].valid & re_i[p] & (raddr[p] == resp_q[p].addr);
        assign rdata_o[p*DataWidth +: DataWidth] = resp_q[p].data;
        assign pend[p]     = re_i[p] & ~rvalid_o[p];

`ifdef SPATZ_VRF_BYPASS_EN
        assign fwd[p] = we_i & pend[p] & (raddr[p] == waddr_i);
`else
        assign fwd[p] = 1'b0;
`endif
    end

    always_comb begin
        for (int b = 0; b < NrBanks; b++) begin
            bank_free[b] = ~(we_i & (wbank == BankW'(b)));
            for (int p = 0; p < NrReadPorts; p++) begin
                bank_req[b][p] = pend[p] & (rbank[p] == BankW'(b));
            end
        end
    end

    for (genvar b = 0; b < NrBanks; b++) begin : g_bank
        spatz_vrf_rr_arb #(
            .NrPorts (NrReadPorts)
        ) i_arb (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .req_i  (bank_req[b]),
            .en_i   (bank_free[b]),
            .gnt_o  (bank_gnt[b])
        );
    end

    always_comb begin
        port_gnt = '0;
        for (int b = 0; b < NrBanks; b++) port_gnt = port_gnt | bank_gnt[b];
    end

    always_comb begin
        for (int p = 0; p < NrReadPorts; p++) begin
            resp_d[p]       = resp_q[p];
            resp_d[p].valid = resp_q[p].valid & rvalid_o[p];
            // Keep a held word coherent with a write landing on the same address.
            if (we_i && resp_q[p].valid && (waddr_i == resp_q[p].addr)) begin
                resp_d[p].data = be_merge(resp_q[p].data, wdata_i, wbe_i);
            end
            if (fwd[p]) begin
                resp_d[p].valid = 1'b1;
                resp_d[p].addr  = raddr[p];
                resp_d[p].data  = be_merge(row_dat[p], wdata_i, wbe_i);
            end else if (port_gnt[p]) begin
                resp_d[p].valid = 1'b1;
                resp_d[p].addr  = raddr[p];
                resp_d[p].data  = row_dat[p];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) resp_q <= '{default: '0};
        else         resp_q <= resp_d;
    end

endmodule

// File: tb/tb_spatz_vrf_responder.sv
// Bench for spatz_vrf_responder: cycle vector table with expected rvalid, plus a read-data scoreboard.
// Define SPATZ_VRF_BYPASS_EN for the write-forwarding build.
module tb_spatz_vrf_responder;
    localparam int NP = 3;
    localparam int NB = 4;
    localparam int AW = 7;
    localparam int DW = 128;
    localparam int BW = 16;

    localparam logic [DW-1:0] ZD   = '0;
    localparam logic [DW-1:0] D_A5 = {16{8'hA5}};
    localparam logic [DW-1:0] D_CO = {{96{1'b1}}, 32'h11223344};
    localparam logic [DW-1:0] D_W1 = {4{32'h0BAD_F00D}};
    localparam logic [DW-1:0] D_W2 = {4{32'h1357_9BDF}};
    localparam logic [DW-1:0] D_BY = {8{16'hBEEF}};

`ifdef SPATZ_VRF_BYPASS_EN
    localparam logic [NP-1:0] BYP_RV = 3'b010;
`else
    localparam logic [NP-1:0] BYP_RV = 3'b000;
`endif

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic [NP*AW-1:0] raddr_i;
    logic [NP-1:0]    re_i;
    logic [NP*DW-1:0] rdata_o;
    logic [NP-1:0]    rvalid_o;
    logic [AW-1:0]    waddr_i;
    logic [DW-1:0]    wdata_i;
    logic             we_i;
    logic [BW-1:0]    wbe_i;
    logic             wvalid_o;

    always #5 clk_i = ~clk_i;

    spatz_vrf_responder dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .raddr_i  (raddr_i),
        .re_i     (re_i),
        .rdata_o  (rdata_o),
        .rvalid_o (rvalid_o),
        .waddr_i  (waddr_i),
        .wdata_i  (wdata_i),
        .we_i     (we_i),
        .wbe_i    (wbe_i),
        .wvalid_o (wvalid_o)
    );

    typedef struct {
        logic [NP-1:0] re;
        logic [AW-1:0] a0, a1, a2;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [BW-1:0] wbe;
        logic [NP-1:0] exp_rv;
    } vec_t;

    typedef struct {
        int            port;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sb_t;

    vec_t          tv[$];
    sb_t           sbq[$];
    logic [DW-1:0] model    [NB*32];
    logic [DW-1:0] held_exp [NP];
    logic [AW-1:0] prev_addr[NP];
    logic [NP-1:0] prev_rv, prev_re, last_rv;
    int            n_chk = 0;
    int            n_fail = 0;
    int            lat;

    task automatic chk(input string name, input logic [NP*DW-1:0] act, input logic [NP*DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_d, input logic [DW-1:0] new_d,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old_d;
        for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [AW-1:0] ra(input int p);
        return raddr_i[p*AW +: AW];
    endfunction

    function automatic vec_t v(input logic [NP-1:0] re, input int a0, input int a1, input int a2,
                               input logic we, input int wa, input logic [DW-1:0] wd,
                               input logic [BW-1:0] wbe, input logic [NP-1:0] exp_rv);
        vec_t r;
        r.re = re; r.a0 = AW'(a0); r.a1 = AW'(a1); r.a2 = AW'(a2);
        r.we = we; r.wa = AW'(wa); r.wd = wd; r.wbe = wbe; r.exp_rv = exp_rv;
        return r;
    endfunction

    // One clock cycle with the inputs already driven: check outputs, then update model and scoreboard.
    task automatic step(input bit do_rv, input logic [NP-1:0] exp_rv, input int row);
        int idx;
        @(negedge clk_i);
        last_rv = rvalid_o;
        chk($sformatf("wvalid row %0d", row), wvalid_o, 1'b1);
        if (do_rv) chk($sformatf("rvalid row %0d", row), rvalid_o, exp_rv);
        for (int p = 0; p < NP; p++) begin
            if (rvalid_o[p]) begin
                if (prev_rv[p] && prev_addr[p] == ra(p)) begin
                    chk($sformatf("held rdata p%0d row %0d", p, row), rdata_o[p*DW +: DW], held_exp[p]);
                end else begin
                    idx = -1;
                    foreach (sbq[i]) if (idx < 0 && sbq[i].port == p) idx = i;
                    if (idx < 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected response p%0d row %0d: got rvalid with no request outstanding", p, row);
                    end else begin
                        chk($sformatf("rdata p%0d row %0d", p, row), rdata_o[p*DW +: DW], sbq[idx].data);
                        held_exp[p] = sbq[idx].data;
                        sbq.delete(idx);
                    end
                end
            end
        end
        if (we_i) begin
            model[waddr_i] = merge(model[waddr_i], wdata_i, wbe_i);
            foreach (sbq[i]) if (sbq[i].addr == waddr_i) sbq[i].data = merge(sbq[i].data, wdata_i, wbe_i);
            for (int p = 0; p < NP; p++)
                if (rvalid_o[p] && ra(p) == waddr_i) held_exp[p] = merge(held_exp[p], wdata_i, wbe_i);
        end
        for (int p = 0; p < NP; p++) begin
            if (re_i[p] && !(prev_re[p] && prev_addr[p] == ra(p)))
                sbq.push_back('{port: p, addr: ra(p), data: model[ra(p)]});
            prev_addr[p] = ra(p);
        end
        prev_rv = rvalid_o;
        prev_re = re_i;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        re_i = '0; raddr_i = '0; we_i = 1'b0; waddr_i = '0; wdata_i = '0; wbe_i = '0;
        prev_rv = '0; prev_re = '0; last_rv = '0;
        for (int p = 0; p < NP; p++) begin
            prev_addr[p] = '0;
            held_exp[p]  = '0;
        end

        // Single read after full write, hold while requested
        tv.push_back(v(3'b000, 0, 0, 0, 1'b1, 5, D_A5, 16'hFFFF, 3'b000));
        tv.push_back(v(3'b001, 5, 0, 0, 1'b0, 0, ZD, 16'h0, 3'b000));
        tv.push_back(v(3'b001, 5, 0, 0, 1'b0, 0, ZD, 16'h0, 3'b001));
        tv.push_back(v(3'b001, 5, 0, 0, 1'b0, 0, ZD, 16'h0, 3'b001));
        tv.push_back(v(3'b000, 0, 0, 0, 1'b0, 0, ZD, 16'h0, 3'b000));
        // Three-way conflict on bank 0, pointer at 0
        tv.push_back(v(3'b111, 0, 4, 8, 1'b0, 0, ZD, 16'h0, 3'b000));
        tv.push_back(v(3'b111, 0, 4, 8, 1'b0, 0, ZD, 16'h0, 3'b001));
        tv.push_back(v(3'b111, 0, 4, 8, 1'b0, 0, ZD, 16'h0, 3'b011));
        tv.push_back(v(3'b111, 0, 4, 8, 1'b0, 0, ZD, 16'h0, 3'b111));
        tv.push_back(v(3'b000, 0, 0, 0, 1'b0, 0, ZD, 16'h0, 3'b000));
        // Move bank 0 pointer to 1, then conflict again
        tv.push_back(v(3'b001, 12, 0, 0, 1'b0, 0, ZD, 16'h0, 3'b000));
        tv.push_back(v(3'b001, 12, 0, 0, 1'b0, 0, ZD, 16'h0, 3'b001));
        tv.push_back(v(3'b000, 0, 0, 0, 1'b0, 0, ZD, 16'h0, 3'b000));
        tv.push_back(v(3'b111, 0, 4, 8, 1'b0, 0, ZD, 16'h0, 3'b000));
        tv.push_back(v(3'b111, 0, 4, 8, 1'b0, 0, ZD, 16'h0, 3'b010));
        tv.push_back(v(3'b111, 0, 4, 8, 1'b0, 0, ZD, 16'h0, 3'b110));
        tv.push_back(v(3'b111, 0, 4, 8, 1'b0, 0, ZD, 16'h0, 3'b111));
        tv.push_back(v(3'b000, 0, 0, 0, 1'b0, 0, ZD, 16'h0, 3'b000));
        // Distinct banks in parallel
        tv.push_back(v(3'b111, 0, 1, 2, 1'b0, 0, ZD, 16'h0, 3'b000));
        tv.push_back(v(3'b111, 0, 1, 2, 1'b0, 0, ZD, 16'h0, 3'b111));
        tv.push_back(v(3'b000, 0, 0, 0, 1'b0, 0, ZD, 16'h0, 3'b000));
        // Partial write into a held response
        tv.push_back(v(3'b001, 3, 0, 0, 1'b0, 0, ZD, 16'h0, 3'b000));
        tv.push_back(v(3'b001, 3, 0, 0, 1'b0, 0, ZD, 16'h0, 3'b001));
        tv.push_back(v(3'b001, 3, 0, 0, 1'b1, 3, D_CO, 16'h000F, 3'b001));
        tv.push_back(v(3'b001, 3, 0, 0, 1'b0, 0, ZD, 16'h0, 3'b001));
        tv.push_back(v(3'b000, 0, 0, 0, 1'b0, 0, ZD, 16'h0, 3'b000));
        // Writes hog bank 1 while port 1 waits
        tv.push_back(v(3'b010, 0, 17, 0, 1'b1, 9, D_W1, 16'hFFFF, 3'b000));
        tv.push_back(v(3'b010, 0, 17, 0, 1'b1, 13, D_W2, 16'hFFFF, 3'b000));
        tv.push_back(v(3'b010, 0, 17, 0, 1'b1, 9, D_W2, 16'hFFFF, 3'b000));
        tv.push_back(v(3'b010, 0, 17, 0, 1'b0, 0, ZD, 16'h0, 3'b000));
        tv.push_back(v(3'b010, 0, 17, 0, 1'b0, 0, ZD, 16'h0, 3'b010));
        tv.push_back(v(3'b000, 0, 0, 0, 1'b0, 0, ZD, 16'h0, 3'b000));
        // Read and partial write to the same address in the same cycle
        tv.push_back(v(3'b010, 0, 21, 0, 1'b1, 21, D_BY, 16'h00FF, 3'b000));
        tv.push_back(v(3'b010, 0, 21, 0, 1'b0, 0, ZD, 16'h0, BYP_RV));
        tv.push_back(v(3'b010, 0, 21, 0, 1'b0, 0, ZD, 16'h0, 3'b010));
        tv.push_back(v(3'b000, 0, 0, 0, 1'b0, 0, ZD, 16'h0, 3'b000));
        // Streaming addresses on port 0
        for (int a = 0; a < 4; a++) begin
            tv.push_back(v(3'b001, a, 0, 0, 1'b0, 0, ZD, 16'h0, 3'b000));
            tv.push_back(v(3'b001, a, 0, 0, 1'b0, 0, ZD, 16'h0, 3'b001));
        end

        repeat (3) @(posedge clk_i);
        #1;
        chk("reset rvalid", rvalid_o, '0);
        chk("reset rdata", rdata_o, '0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("post-reset rdata", rdata_o, '0);

        for (int a = 0; a < NB*32; a++) begin
            we_i = 1'b1; waddr_i = AW'(a); wbe_i = '1;
            wdata_i = {$urandom, $urandom, $urandom, $urandom};
            step(1'b1, 3'b000, -1);
        end
        we_i = 1'b0;

        foreach (tv[i]) begin
            re_i    = tv[i].re;
            raddr_i = {tv[i].a2, tv[i].a1, tv[i].a0};
            we_i    = tv[i].we;
            waddr_i = tv[i].wa;
            wdata_i = tv[i].wd;
            wbe_i   = tv[i].wbe;
            step(1'b1, tv[i].exp_rv, i);
        end

        // Asynchronous reset while port 0 holds a response, then re-request
        chk("hold before reset", rvalid_o, 3'b001);
        #2 rst_ni = 1'b0;
        #1;
        chk("async reset rvalid", rvalid_o, '0);
        chk("async reset rdata", rdata_o, '0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        sbq.delete();
        prev_rv = '0;
        prev_re = '0;
        lat = 0;
        do begin
            step(1'b0, '0, 100 + lat);
            lat++;
        end while (!last_rv[0] && lat < 8);
        chk("re-request latency cycles", lat, 2);

        re_i = '0;
        step(1'b1, 3'b000, 200);
        chk("scoreboard drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
